// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// div_seq_ctrl : runs one divide at a time through the signed or unsigned
//                divider IP, with flush handling for in-flight operations.
// Revision: 1.0
// ============================================================================
module div_seq_ctrl #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  input  logic [3:0]     req_op,
  input  logic [W-1:0]   req_src1,
  input  logic [W-1:0]   req_src2,
  output logic           req_ready,
  input  logic           flush,
  output logic           s_dvd_tvalid_s,
  output logic           s_dvs_tvalid_s,
  output logic           s_dvd_tvalid_u,
  output logic           s_dvs_tvalid_u,
  input  logic           s_dvd_tready_s,
  input  logic           s_dvs_tready_s,
  input  logic           s_dvd_tready_u,
  input  logic           s_dvs_tready_u,
  output logic [W-1:0]   s_dvd_tdata,
  output logic [W-1:0]   s_dvs_tdata,
  input  logic           m_tvalid_s,
  input  logic           m_tvalid_u,
  input  logic [2*W-1:0] m_tdata_s,
  input  logic [2*W-1:0] m_tdata_u,
  output logic           res_valid,
  output logic [W-1:0]   res_data,
  input  logic           res_ready,
  output logic           busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t         r_state;
  logic [3:0]     r_op;
  logic [W-1:0]   r_src1;
  logic [W-1:0]   r_src2;
  logic           r_dvd_tvalid_s;
  logic           r_dvs_tvalid_s;
  logic           r_dvd_tvalid_u;
  logic           r_dvs_tvalid_u;
  logic           r_dvd_acc;
  logic           r_dvs_acc;
  logic           r_flushed;
  logic           r_res_valid;
  logic [W-1:0]   r_res_data;

  logic           w_req_onehot;
  logic           w_req_signed;
  logic           w_op_signed;
  logic           w_op_div;
  logic           w_dvd_hs;
  logic           w_dvs_hs;
  logic           w_dvd_done;
  logic           w_dvs_done;
  logic           w_m_tvalid;
  logic [2*W-1:0] w_m_tdata;
  logic [W-1:0]   w_m_result;

  assign w_req_onehot = (req_op != 4'd0) && ((req_op & (req_op - 4'd1)) == 4'd0);
  assign w_req_signed = req_op[3] | req_op[2];
  assign w_op_signed  = r_op[3] | r_op[2];
  assign w_op_div     = r_op[3] | r_op[1];

  // Only the selected IP ever has its valids set, so OR-ing both IPs is safe.
  assign w_dvd_hs   = (r_dvd_tvalid_s & s_dvd_tready_s) | (r_dvd_tvalid_u & s_dvd_tready_u);
  assign w_dvs_hs   = (r_dvs_tvalid_s & s_dvs_tready_s) | (r_dvs_tvalid_u & s_dvs_tready_u);
  assign w_dvd_done = r_dvd_acc | w_dvd_hs;
  assign w_dvs_done = r_dvs_acc | w_dvs_hs;

  assign w_m_tvalid = w_op_signed ? m_tvalid_s : m_tvalid_u;
  assign w_m_tdata  = w_op_signed ? m_tdata_s  : m_tdata_u;
  assign w_m_result = w_op_div ? w_m_tdata[2*W-1:W] : w_m_tdata[W-1:0];

  assign req_ready      = (r_state == S_IDLE) && !flush;
  assign busy           = (r_state != S_IDLE);
  assign s_dvd_tvalid_s = r_dvd_tvalid_s;
  assign s_dvs_tvalid_s = r_dvs_tvalid_s;
  assign s_dvd_tvalid_u = r_dvd_tvalid_u;
  assign s_dvs_tvalid_u = r_dvs_tvalid_u;
  assign s_dvd_tdata    = r_src1;
  assign s_dvs_tdata    = r_src2;
  assign res_valid      = r_res_valid;
  assign res_data       = r_res_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_op           <= 4'd0;
      r_src1         <= '0;
      r_src2         <= '0;
      r_dvd_tvalid_s <= 1'b0;
      r_dvs_tvalid_s <= 1'b0;
      r_dvd_tvalid_u <= 1'b0;
      r_dvs_tvalid_u <= 1'b0;
      r_dvd_acc      <= 1'b0;
      r_dvs_acc      <= 1'b0;
      r_flushed      <= 1'b0;
      r_res_valid    <= 1'b0;
      r_res_data     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && w_req_onehot && !flush) begin
            r_op           <= req_op;
            r_src1         <= req_src1;
            r_src2         <= req_src2;
            r_dvd_tvalid_s <= w_req_signed;
            r_dvs_tvalid_s <= w_req_signed;
            r_dvd_tvalid_u <= !w_req_signed;
            r_dvs_tvalid_u <= !w_req_signed;
            r_dvd_acc      <= 1'b0;
            r_dvs_acc      <= 1'b0;
            r_flushed      <= 1'b0;
            r_state        <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (w_dvd_hs) begin
            r_dvd_tvalid_s <= 1'b0;
            r_dvd_tvalid_u <= 1'b0;
            r_dvd_acc      <= 1'b1;
          end
          if (w_dvs_hs) begin
            r_dvs_tvalid_s <= 1'b0;
            r_dvs_tvalid_u <= 1'b0;
            r_dvs_acc      <= 1'b1;
          end
          // Once the IP holds any operand it will produce a result, so a
          // flush can only be honoured by draining that result.
          if (w_dvd_done && w_dvs_done) begin
            r_state <= (flush || r_flushed) ? S_DRAIN : S_WAIT;
          end else if (flush && !w_dvd_done && !w_dvs_done) begin
            r_dvd_tvalid_s <= 1'b0;
            r_dvs_tvalid_s <= 1'b0;
            r_dvd_tvalid_u <= 1'b0;
            r_dvs_tvalid_u <= 1'b0;
            r_state        <= S_IDLE;
          end else if (flush) begin
            r_flushed <= 1'b1;
          end
        end

        S_WAIT: begin
          if (flush && w_m_tvalid) begin
            r_state <= S_IDLE;
          end else if (flush) begin
            r_state <= S_DRAIN;
          end else if (w_m_tvalid) begin
            r_res_data  <= w_m_result;
            r_res_valid <= 1'b1;
            r_state     <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (flush || res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        S_DRAIN: begin
          if (w_m_tvalid) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_div_seq_ctrl : scenario tasks plus randomized ops against an arithmetic
//                   model of the divider IPs.
// Revision: 1.0
// ============================================================================
module tb_div_seq_ctrl;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           req_valid;
  logic [3:0]     req_op;
  logic [W-1:0]   req_src1, req_src2;
  logic           req_ready;
  logic           flush;
  logic           s_dvd_tvalid_s, s_dvs_tvalid_s, s_dvd_tvalid_u, s_dvs_tvalid_u;
  logic           s_dvd_tready_s, s_dvs_tready_s, s_dvd_tready_u, s_dvs_tready_u;
  logic [W-1:0]   s_dvd_tdata, s_dvs_tdata;
  logic           m_tvalid_s, m_tvalid_u;
  logic [2*W-1:0] m_tdata_s, m_tdata_u;
  logic           res_valid;
  logic [W-1:0]   res_data;
  logic           res_ready;
  logic           busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_seq_ctrl #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_src1(req_src1), .req_src2(req_src2),
    .req_ready(req_ready), .flush(flush),
    .s_dvd_tvalid_s(s_dvd_tvalid_s), .s_dvs_tvalid_s(s_dvs_tvalid_s),
    .s_dvd_tvalid_u(s_dvd_tvalid_u), .s_dvs_tvalid_u(s_dvs_tvalid_u),
    .s_dvd_tready_s(s_dvd_tready_s), .s_dvs_tready_s(s_dvs_tready_s),
    .s_dvd_tready_u(s_dvd_tready_u), .s_dvs_tready_u(s_dvs_tready_u),
    .s_dvd_tdata(s_dvd_tdata), .s_dvs_tdata(s_dvs_tdata),
    .m_tvalid_s(m_tvalid_s), .m_tvalid_u(m_tvalid_u),
    .m_tdata_s(m_tdata_s), .m_tdata_u(m_tdata_u),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready), .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req_valid = 0; req_op = 0; req_src1 = 0; req_src2 = 0; flush = 0;
    s_dvd_tready_s = 0; s_dvs_tready_s = 0; s_dvd_tready_u = 0; s_dvs_tready_u = 0;
    m_tvalid_s = 0; m_tvalid_u = 0; m_tdata_s = 0; m_tdata_u = 0; res_ready = 0;
  endtask

  // Divider IP behaviour: {quotient, remainder}; divide by zero gives all-ones / dividend.
  function automatic logic [2*W-1:0] ip_model(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r;
    if (b == 0) begin
      q = '1; r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return {q, r};
  endfunction

  function automatic logic [W-1:0] expect_res(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] m;
    m = ip_model(op[3] | op[2], a, b);
    return (op[3] | op[1]) ? m[2*W-1:W] : m[W-1:0];
  endfunction

  // Drives one full operation and reports what it saw; callers do the comparisons.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int dvd_dly, input int dvs_dly, input int ip_lat, input int rr_dly,
                        output logic [W-1:0] got, output int proto_err, output int hold_err,
                        output int n_issue, output bit timeout);
    bit sgn;
    bit dvd_done, dvs_done, rd, rs;
    logic [2*W-1:0] ip;
    logic v_dvd, v_dvs;
    int k;
    sgn = op[3] | op[2];
    ip = ip_model(sgn, a, b);
    dvd_done = 0; dvs_done = 0;
    proto_err = 0; hold_err = 0; timeout = 0; got = '0;
    req_valid = 1; req_op = op; req_src1 = a; req_src2 = b;
    if (req_ready !== 1'b1) proto_err++;
    tick;
    req_valid = 0; req_src1 = $urandom; req_src2 = $urandom;
    k = 0;
    while (!(dvd_done && dvs_done)) begin
      v_dvd = sgn ? s_dvd_tvalid_s : s_dvd_tvalid_u;
      v_dvs = sgn ? s_dvs_tvalid_s : s_dvs_tvalid_u;
      if ((sgn ? (s_dvd_tvalid_u | s_dvs_tvalid_u) : (s_dvd_tvalid_s | s_dvs_tvalid_s)) !== 1'b0) proto_err++;
      if (s_dvd_tdata !== a || s_dvs_tdata !== b || busy !== 1'b1) proto_err++;
      if (v_dvd !== !dvd_done || v_dvs !== !dvs_done) proto_err++;
      rd = (k >= dvd_dly); rs = (k >= dvs_dly);
      s_dvd_tready_s = sgn ? rd : 1'($urandom);
      s_dvs_tready_s = sgn ? rs : 1'($urandom);
      s_dvd_tready_u = sgn ? 1'($urandom) : rd;
      s_dvs_tready_u = sgn ? 1'($urandom) : rs;
      tick;
      dvd_done = dvd_done | rd;
      dvs_done = dvs_done | rs;
      k++;
      if (k > 100) begin timeout = 1; break; end
    end
    n_issue = k;
    s_dvd_tready_s = 0; s_dvs_tready_s = 0; s_dvd_tready_u = 0; s_dvs_tready_u = 0;
    for (int j = 0; j < ip_lat; j++) begin
      if ({s_dvd_tvalid_s, s_dvs_tvalid_s, s_dvd_tvalid_u, s_dvs_tvalid_u} !== 4'b0) proto_err++;
      if (res_valid !== 1'b0 || busy !== 1'b1) proto_err++;
      if (sgn) begin m_tvalid_u = 1; m_tdata_u = {$urandom, $urandom}; end
      else     begin m_tvalid_s = 1; m_tdata_s = {$urandom, $urandom}; end
      tick;
    end
    if (res_valid !== 1'b0) proto_err++;
    m_tvalid_s = sgn; m_tvalid_u = !sgn;
    if (sgn) begin m_tdata_s = ip; m_tdata_u = {$urandom, $urandom}; end
    else     begin m_tdata_u = ip; m_tdata_s = {$urandom, $urandom}; end
    tick;
    m_tvalid_s = 0; m_tvalid_u = 0; m_tdata_s = {$urandom, $urandom}; m_tdata_u = {$urandom, $urandom};
    if (res_valid !== 1'b1) proto_err++;
    got = res_data;
    for (int j = 0; j < rr_dly; j++) begin
      req_valid = 1; req_op = 4'b1000; req_src1 = $urandom; req_src2 = $urandom;
      if (res_valid !== 1'b1 || res_data !== got || req_ready !== 1'b0) hold_err++;
      tick;
      if (res_valid !== 1'b1 || res_data !== got || busy !== 1'b1) hold_err++;
    end
    req_valid = 0; res_ready = 1;
    tick;
    res_ready = 0;
    if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) hold_err++;
  endtask

  // Brings an op through a zero-wait handshake so the DUT sits in WAIT.
  task automatic start_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid = 1; req_op = op; req_src1 = a; req_src2 = b;
    tick;
    req_valid = 0;
    s_dvd_tready_s = 1; s_dvs_tready_s = 1; s_dvd_tready_u = 1; s_dvs_tready_u = 1;
    tick;
    s_dvd_tready_s = 0; s_dvs_tready_s = 0; s_dvd_tready_u = 0; s_dvs_tready_u = 0;
  endtask

  task automatic test_reset;
    clear_inputs();
    reset = 1; req_valid = 1; req_op = 4'b1000; req_src1 = 7; req_src2 = 2;
    tick; tick;
    reset = 0; req_valid = 0;
    checks++;
    if ({busy, res_valid, s_dvd_tvalid_s, s_dvs_tvalid_s, s_dvd_tvalid_u, s_dvs_tvalid_u} !== 6'b0 ||
        res_data !== '0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: busy=%b res_valid=%b res_data=%h req_ready=%b, required 0/0/0/1",
               busy, res_valid, res_data, req_ready);
    end
  endtask

  task automatic test_directed(input string name, input logic [3:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input int dvd_dly, input int dvs_dly,
                               input int rr_dly, input logic [W-1:0] req_val);
    logic [W-1:0] got; int pe, he, ni; bit to;
    run_op(op, a, b, dvd_dly, dvs_dly, 0, rr_dly, got, pe, he, ni, to);
    checks++;
    if (got !== req_val) begin
      errors++; $display("FAIL %s_data: got %h, required %h", name, got, req_val);
    end
    checks++;
    if (pe !== 0 || to !== 1'b0) begin
      errors++; $display("FAIL %s_protocol: %0d violations timeout=%0d, required 0/0", name, pe, to);
    end
    checks++;
    if (he !== 0) begin
      errors++; $display("FAIL %s_hold: %0d hold violations, required 0", name, he);
    end
    checks++;
    if (ni !== ((dvd_dly > dvs_dly ? dvd_dly : dvs_dly) + 1)) begin
      errors++; $display("FAIL %s_issue_cycles: got %0d, required %0d", name, ni,
                         (dvd_dly > dvs_dly ? dvd_dly : dvs_dly) + 1);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] got, a, b; logic [3:0] op; int pe, he, ni, bad, dd, ds; bit to;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      op = 4'b0001 << $urandom_range(0, 3);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 0;
        1: b = $urandom_range(1, 9);
        2: b = -$urandom_range(1, 9);
        default: b = $urandom;
      endcase
      dd = $urandom_range(0, 3); ds = $urandom_range(0, 3);
      run_op(op, a, b, dd, ds, $urandom_range(0, 4), $urandom_range(0, 2), got, pe, he, ni, to);
      checks++;
      if (got !== expect_res(op, a, b) || pe !== 0 || he !== 0 || to !== 1'b0 ||
          ni !== ((dd > ds ? dd : ds) + 1)) begin
        errors++; bad++;
        if (bad < 5)
          $display("FAIL random_op%0d: op=%b a=%h b=%h got %h pe=%0d he=%0d, required %h pe=0 he=0",
                   i, op, a, b, got, pe, he, expect_res(op, a, b));
      end
    end
  endtask

  task automatic test_bad_op;
    req_valid = 1; req_op = 4'b0000; tick;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL bad_op_zero: busy=%b, required 0", busy); end
    req_op = 4'b0101; tick;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL bad_op_multi: busy=%b, required 0", busy); end
    req_valid = 0; req_op = 0;
  endtask

  task automatic test_flush_idle;
    req_valid = 1; req_op = 4'b0010; req_src1 = 9; req_src2 = 3; flush = 1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_idle_ready: got %b, required 0", req_ready); end
    tick;
    req_valid = 0; flush = 0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_accept: busy=%b, required 0", busy); end
  endtask

  task automatic test_flush_issue_none;
    req_valid = 1; req_op = 4'b1000; req_src1 = 50; req_src2 = 5;
    tick;
    req_valid = 0; flush = 1;
    tick;
    flush = 0;
    checks++;
    if ({busy, s_dvd_tvalid_s, s_dvs_tvalid_s, s_dvd_tvalid_u, s_dvs_tvalid_u} !== 5'b0) begin
      errors++; $display("FAIL flush_issue_none: busy/tvalids=%b, required 00000",
                         {busy, s_dvd_tvalid_s, s_dvs_tvalid_s, s_dvd_tvalid_u, s_dvs_tvalid_u});
    end
  endtask

  task automatic test_flush_issue_one;
    int rv;
    rv = 0;
    req_valid = 1; req_op = 4'b0010; req_src1 = 100; req_src2 = 7;
    tick;
    req_valid = 0; s_dvs_tready_u = 1;
    tick;
    s_dvs_tready_u = 0; flush = 1;
    tick;
    flush = 0;
    checks++;
    if ({s_dvd_tvalid_u, s_dvs_tvalid_u, busy} !== 3'b101) begin
      errors++; $display("FAIL flush_issue_one_pending: dvd/dvs/busy=%b, required 101",
                         {s_dvd_tvalid_u, s_dvs_tvalid_u, busy});
    end
    tick;
    s_dvd_tready_u = 1;
    tick;
    s_dvd_tready_u = 0;
    flush = 1;
    tick;
    flush = 0;
    checks++;
    if ({s_dvd_tvalid_u, s_dvs_tvalid_u, busy, res_valid} !== 4'b0010) begin
      errors++; $display("FAIL flush_issue_one_drain: dvd/dvs/busy/res_valid=%b, required 0010",
                         {s_dvd_tvalid_u, s_dvs_tvalid_u, busy, res_valid});
    end
    m_tvalid_u = 1; m_tdata_u = ip_model(0, 100, 7);
    tick;
    m_tvalid_u = 0;
    if (res_valid !== 1'b0) rv++;
    tick;
    if (res_valid !== 1'b0) rv++;
    checks++;
    if (busy !== 1'b0 || rv !== 0) begin
      errors++; $display("FAIL flush_issue_one_idle: busy=%b res_valid_hits=%0d, required 0/0", busy, rv);
    end
  endtask

  task automatic test_flush_wait;
    int rv, nb;
    rv = 0; nb = 0;
    start_op(4'b1000, 20, 3);
    flush = 1;
    tick;
    flush = 0;
    for (int j = 0; j < 4; j++) begin
      if (res_valid !== 1'b0) rv++;
      if (busy !== 1'b1) nb++;
      m_tvalid_u = 1; m_tdata_u = {$urandom, $urandom};
      tick;
    end
    m_tvalid_u = 0;
    m_tvalid_s = 1; m_tdata_s = ip_model(1, 20, 3);
    tick;
    m_tvalid_s = 0;
    checks++;
    if (rv !== 0 || nb !== 0) begin
      errors++; $display("FAIL flush_wait_drain: res_valid_hits=%0d not_busy=%0d, required 0/0", rv, nb);
    end
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL flush_wait_idle: res_valid=%b busy=%b req_ready=%b, required 0/0/1",
                         res_valid, busy, req_ready);
    end
  endtask

  task automatic test_flush_wait_mtvalid;
    start_op(4'b0100, 33, 4);
    flush = 1; m_tvalid_s = 1; m_tdata_s = ip_model(1, 33, 4);
    tick;
    flush = 0; m_tvalid_s = 0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_wait_mtvalid: res_valid=%b busy=%b, required 0/0", res_valid, busy);
    end
  endtask

  task automatic test_flush_hold;
    start_op(4'b0001, 33, 4);
    m_tvalid_u = 1; m_tdata_u = ip_model(0, 33, 4);
    tick;
    m_tvalid_u = 0;
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'd1) begin
      errors++; $display("FAIL flush_hold_pre: res_valid=%b res_data=%h, required 1/00000001", res_valid, res_data);
    end
    flush = 1;
    tick;
    flush = 0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_hold: res_valid=%b busy=%b, required 0/0", res_valid, busy);
    end
  endtask

  task automatic test_reset_wait;
    start_op(4'b1000, 91, 7);
    reset = 1;
    tick;
    reset = 0;
    checks++;
    if (busy !== 1'b0 || res_data !== '0) begin
      errors++; $display("FAIL reset_wait: busy=%b res_data=%h, required 0/00000000", busy, res_data);
    end
    m_tvalid_s = 1; m_tdata_s = ip_model(1, 91, 7);
    tick;
    m_tvalid_s = 0;
    tick;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_stale_mtvalid: res_valid=%b busy=%b, required 0/0", res_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_directed("div_w", 4'b1000, 32'd7, 32'd2, 0, 0, 2, 32'h0000_0003);
    test_directed("mod_w", 4'b0100, 32'hFFFF_FFF9, 32'd2, 0, 0, 1, 32'hFFFF_FFFF);
    test_directed("div_wu_stagger", 4'b0010, 32'hFFFF_FFFF, 32'd2, 2, 0, 0, 32'h7FFF_FFFF);
    test_directed("hold_3", 4'b0001, 32'd29, 32'd5, 1, 3, 3, 32'd4);
    test_directed("divzero_s", 4'b1000, 32'd12, 32'd0, 0, 0, 0, 32'hFFFF_FFFF);
    test_directed("divzero_u", 4'b0001, 32'hABCD_0123, 32'd0, 0, 1, 0, 32'hABCD_0123);
    test_bad_op();
    test_flush_idle();
    test_flush_issue_none();
    test_flush_issue_one();
    test_flush_wait();
    test_flush_wait_mtvalid();
    test_flush_hold();
    test_reset_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_seq_ctrl.md
DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

Interface
REQ-001 Parameter: W, 32, operand and result width in bits.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 req_valid  in  1  divide request from EXE.
REQ-005 req_op  in  4  one-hot {div_w, mod_w, div_wu, mod_wu}.
REQ-006 req_src1 / req_src2  in  W each  dividend / divisor.
REQ-007 req_ready  out  1  request accepted this cycle.
REQ-008 flush  in  1  exception/ertn flush from WB; kills the in-flight operation.
REQ-009 s_dvd_tvalid_s, s_dvs_tvalid_s, s_dvd_tvalid_u, s_dvs_tvalid_u  out  1 each  dividend/divisor channel valid to signed/unsigned divider IP.
REQ-010 s_dvd_tready_s, s_dvs_tready_s, s_dvd_tready_u, s_dvs_tready_u  in  1 each  matching IP channel ready.
REQ-011 s_dvd_tdata, s_dvs_tdata  out  W each  latched operands, shared by both IPs.
REQ-012 m_tvalid_s, m_tvalid_u  in  1 each  IP result valid.
REQ-013 m_tdata_s, m_tdata_u  in  2W each  {quotient, remainder}.
REQ-014 res_valid  out  1  result available to EXE.
REQ-015 res_data  out  W  selected quotient or remainder.
REQ-016 res_ready  in  1  EXE consumes result.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, HOLD, DRAIN.
REQ-019 req_ready SHALL be 1 only in IDLE with flush=0.
REQ-020 IDLE: req_valid=1, req_op exactly one-hot, flush=0 -> latch op, src1, src2; next state ISSUE.
REQ-021 IDLE: req_op zero or multi-hot -> request ignored, state unchanged.
REQ-022 ISSUE: tvalid SHALL be driven only on the IP selected by op (signed for div_w/mod_w, unsigned for div_wu/mod_wu); the other IP's tvalids stay 0.
REQ-023 ISSUE: each channel tracked by an accepted flag; a channel's tvalid SHALL drop the cycle after its tvalid&tready handshake and SHALL never reassert for that operation.
REQ-024 ISSUE -> WAIT when both channels are accepted, including the same-cycle case.
REQ-025 WAIT: selected m_tvalid=1 -> register res_data (quotient for div ops, remainder for mod ops); next state HOLD.
REQ-026 WAIT: m_tvalid of the non-selected IP SHALL be ignored.
REQ-027 HOLD: res_valid=1 and res_data stable until res_ready=1; then IDLE.
REQ-028 Minimum latency: request accepted at cycle T, both channels ready at T+1 -> WAIT at T+2; res_valid one cycle after m_tvalid.
REQ-029 Divide by zero SHALL pass through unchanged; IP output is returned as-is.
REQ-030 flush in ISSUE, no channel accepted yet -> all tvalids 0 next cycle; state IDLE.
REQ-031 flush in ISSUE, one channel accepted -> remaining channel completes its handshake, then DRAIN.
REQ-032 flush in WAIT -> DRAIN.
REQ-033 flush in WAIT coincident with m_tvalid -> result discarded; state IDLE.
REQ-034 DRAIN: wait for selected m_tvalid, discard the result, then IDLE; res_valid stays 0.
REQ-035 flush in HOLD -> res_valid=0 next cycle; state IDLE.
REQ-036 flush in IDLE blocks acceptance that cycle.
REQ-037 flush also asserted during DRAIN SHALL have no further effect.

Reset
REQ-038 reset SHALL force IDLE, all tvalids 0, res_valid 0, res_data 0, busy 0, and clear accepted flags and the latched op.
REQ-039 reset SHALL take priority over all other inputs in the same cycle.
REQ-040 After reset, any m_tvalid from a pre-reset operation SHALL be ignored while in IDLE.

Verification
REQ-041 div_w 7/2, all readies high, m_tvalid_s with {3,1} -> res_data=0x00000003, res_valid held until res_ready.
REQ-042 mod_w 0xFFFFFFF9/2, IP returns {0xFFFFFFFD,0xFFFFFFFF} -> res_data=0xFFFFFFFF; unsigned tvalids stay 0 throughout.
REQ-043 div_wu 0xFFFFFFFF/2, s_dvs_tready_u high 2 cycles before s_dvd_tready_u -> s_dvs_tvalid_u drops the cycle after its handshake, s_dvd_tvalid_u held; res_data=0x7FFFFFFF.
REQ-044 flush in WAIT, then m_tvalid_s 5 cycles later -> res_valid never asserts, DRAIN->IDLE, req_ready=1 next cycle.
REQ-045 res_ready held low 3 cycles in HOLD with src operands changed on inputs -> res_data constant, no new request accepted.
REQ-046 reset asserted in WAIT -> next cycle IDLE, busy=0; a following m_tvalid_s produces no res_valid.
